// File: rtl/up_down_counter.sv
// Signed up/down counter with programmable signed step and signed-overflow detection.
// Define UDC_SATURATE_EN to clamp on overflow instead of wrapping.
module up_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up,
    input  logic             dn,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] count
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] next_increment;
    logic [WIDTH-1:0] next_decrement;
    logic             overflow_up;
    logic             overflow_dn;
    logic [WIDTH-1:0] count_next;

    assign next_increment = count + b;
    assign next_decrement = count - b;

    // Same-sign operands whose result flips sign mean the true sum left the range.
    assign overflow_up = (count[MSB] == b[MSB]) && (next_increment[MSB] != count[MSB]);
    assign overflow_dn = (count[MSB] != b[MSB]) && (next_decrement[MSB] != count[MSB]);

`ifdef UDC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        count_next = count;
        if (up && !dn) begin
            if (overflow_up) begin
                count_next = b[MSB] ? SAT_MIN : SAT_MAX;
            end else begin
                count_next = next_increment;
            end
        end else if (dn && !up) begin
            // Subtracting a negative step overflows upward, a positive one downward.
            if (overflow_dn) begin
                count_next = b[MSB] ? SAT_MAX : SAT_MIN;
            end else begin
                count_next = next_decrement;
            end
        end
    end
`else
    always_comb begin
        count_next = count;
        if (up && !dn) begin
            count_next = next_increment;
        end else if (dn && !up) begin
            count_next = next_decrement;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: integer-arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations (follows UDC_SATURATE_EN).
module tb_up_down_counter;

    localparam int W    = 3;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int SPAN = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         up;
    logic         dn;
    logic [W-1:0] b;
    logic [W-1:0] count;

    int n_tests  = 0;
    int n_failed = 0;

    int m_count  = 0;
    bit m_valid  = 0;

    up_down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up),
        .dn    (dn),
        .b     (b),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap(input int s);
        return ((((s - MINV) % SPAN) + SPAN) % SPAN) + MINV;
    endfunction

    function automatic int settle(input int s);
`ifdef UDC_SATURATE_EN
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
`else
        return wrap(s);
`endif
    endfunction

    function automatic int in_range(input int s);
        return (s >= MINV && s <= MAXV) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: true integer arithmetic, then wrap or clamp.
    always @(posedge clk) begin
        int bs;
        bs = $signed(b);
        if (!rst_n) begin
            m_count = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (up && !dn)      m_count = settle(m_count + bs);
            else if (dn && !up) m_count = settle(m_count - bs);
        end
    end

    always @(negedge clk) begin
        int bs;
        if (m_valid) begin
            bs = $signed(b);
            check("count",          $signed(count),              m_count);
            check("next_increment", $signed(dut.next_increment), wrap(m_count + bs));
            check("next_decrement", $signed(dut.next_decrement), wrap(m_count - bs));
            check("overflow_up",    int'(dut.overflow_up),       1 - in_range(m_count + bs));
            check("overflow_dn",    int'(dut.overflow_dn),       1 - in_range(m_count - bs));
        end
    end

    task automatic step(input logic r, input logic u, input logic d, input int bv);
        rst_n = r;
        up    = u;
        dn    = d;
        b     = W'(bv);
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef UDC_SATURATE_EN
        localparam bit SAT = 1'b1;
`else
        localparam bit SAT = 1'b0;
`endif
        rst_n = 1'b0;
        up    = 1'b0;
        dn    = 1'b0;
        b     = '0;

        // 1: reset dominates up
        step(0, 1, 0, 1);
        check("rst_cycle1", $signed(count), 0);
        step(0, 1, 0, 1);
        check("rst_cycle2", $signed(count), 0);
        check("rst_ovf_up", int'(dut.overflow_up), 0);

        // 2: count up to +3, then overflow
        step(1, 1, 0, 1);
        check("up_1", $signed(count), 1);
        step(1, 1, 0, 1);
        check("up_2", $signed(count), 2);
        step(1, 1, 0, 1);
        check("up_3", $signed(count), 3);
        check("up_3_ni", $signed(dut.next_increment), -4);
        check("up_3_ovf", int'(dut.overflow_up), 1);
        step(1, 1, 0, 1);
        check("up_ovf_result", $signed(count), SAT ? 3 : -4);

        // 3: down from -4 with b=1
        step(0, 0, 0, 0);
        step(1, 1, 0, -4);
        check("to_min", $signed(count), -4);
        dn = 1'b1; up = 1'b0; b = W'(1);
        #1;
        check("dn_min_nd", $signed(dut.next_decrement), 3);
        check("dn_min_ovf", int'(dut.overflow_dn), 1);
        step(1, 0, 1, 1);
        check("dn_ovf_result", $signed(count), SAT ? -4 : 3);
        step(0, 0, 0, 0);
        step(1, 1, 0, 2);
        check("from2", $signed(count), 2);
        step(1, 0, 1, 1);
        check("dn_1", $signed(count), 1);
        step(1, 0, 1, 1);
        check("dn_0", $signed(count), 0);
        step(1, 0, 1, 1);
        check("dn_m1", $signed(count), -1);
        check("dn_m1_ovf", int'(dut.overflow_dn), 0);

        // 4: b=-4 upward
        step(0, 0, 0, 0);
        step(1, 1, 0, -4);
        check("bmin_up1", $signed(count), -4);
        check("bmin_up1_ovf", int'(dut.overflow_up), 1);
        step(1, 1, 0, -4);
        check("bmin_up2", $signed(count), SAT ? -4 : 0);

        // 5: b=-4 downward from 0
        step(0, 0, 0, 0);
        up = 1'b0; dn = 1'b1; b = W'(-4);
        #1;
        check("bmin_dn_nd", $signed(dut.next_decrement), -4);
        check("bmin_dn_ovf", int'(dut.overflow_dn), 1);
        step(1, 0, 1, -4);
        check("bmin_dn", $signed(count), SAT ? 3 : -4);

        // 6: hold and mid-count reset
        step(0, 0, 0, 0);
        step(1, 1, 0, 2);
        step(1, 1, 1, 3);
        check("hold_both", $signed(count), 2);
        step(1, 0, 0, 1);
        check("hold_none", $signed(count), 2);
        step(1, 0, 1, 0);
        check("b_zero", $signed(count), 2);
        step(0, 1, 0, 1);
        check("mid_reset", $signed(count), 0);

        // Sweep every step value both ways; the model checks each cycle.
        for (int bv = MINV; bv <= MAXV; bv++) begin
            step(1, 1, 0, bv);
            step(1, 1, 0, bv);
            step(1, 0, 1, bv);
            step(1, 0, 1, bv);
            step(1, 0, 1, bv);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
